m68k_bus_master_q: RTL and testbench
====================================

Name: m68k_bus_master_q

Overview:
- Parametrised 68000 bus-cycle engine for the CPLD/FPGA bridge. Runs in the fast Pi-side clock domain.
- Accepts read and write commands from the Pi register front-end through a command queue of configurable depth. Writes are posted; read data is returned on a response port.
- Generates 68000-timed bus cycles, derived from a synchronised CPU clock, including the E/VPA/VMA synchronous-peripheral cycle.
- Adds over the single-request engine: queued transactions, a DTACK timeout that terminates hung cycles, sticky error reporting, and BR/BG/BGACK bus arbitration with tristating of the master outputs.

Parameters:
- FIFO_DEPTH, 4: number of command queue entries; power of two, 2..16.
- ADDR_W, 24: width of the 68k address bus.
- SYNC_STAGES, 3: synchroniser depth for M68K_CLK and the sampled bus inputs; minimum 2.
- E_DIV, 10: CPU clocks per E period.
- E_RISE, 5: e_cnt value at which E goes high.
- TIMEOUT_CYC, 256: CPU-clock rising edges in S3 before a cycle is forced to end.

Ports:
- PI_CLK  in  1  fast system clock; all logic is clocked on its rising edge.
- PI_RST  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  queue can accept a command.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  16  write data.
- cmd_rw  in  1  1 = read, 0 = write.
- cmd_byte  in  1  1 = byte access, 0 = word access.
- cmd_fc  in  3  function code.
- rsp_valid  out  1  one-cycle pulse at the end of each read.
- rsp_rdata  out  16  read data.
- rsp_berr  out  1  the read ended with BERR.
- rsp_tmo  out  1  the read ended by timeout.
- err_sticky  out  1  a write ended with BERR or timeout.
- err_clr  in  1  clears err_sticky.
- busy  out  1  a queued command exists or a bus cycle is active.
- M68K_CLK  in  1  CPU clock, asynchronous to PI_CLK.
- M68K_A  out  ADDR_W  address.
- M68K_D_OUT  out  16  write data.
- M68K_D_IN  in  16  read data.
- M68K_D_OE  out  1  data output enable.
- M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_VMA_n  out  1 each  bus strobes.
- M68K_FC  out  3  function code.
- M68K_BUS_OE  out  1  enables the master outputs; 0 = tristate.
- M68K_DTACK_n, M68K_BERR_n, M68K_VPA_n, M68K_BR_n, M68K_BGACK_n  in  1 each.
- M68K_BG_n  out  1  bus grant.
- M68K_E  out  1  E clock.

Behaviour:
- Reset values:
  - AS_n, UDS_n, LDS_n, RW, VMA_n, BG_n, E are 1; FC = 3'b111.
  - D_OE = 0, BUS_OE = 1.
  - Queue empty, cmd_ready = 1.
  - rsp_valid, rsp_berr, rsp_tmo, err_sticky, busy are 0.
  - e_cnt = 0, state = IDLE.
- Reset asserted mid-cycle: the outputs above take their reset values on the next PI_CLK edge; queued commands are discarded.
- Clock sync:
  - M68K_CLK passes through SYNC_STAGES flops.
  - c_rise and c_fall are decoded from the last two stages.
  - DTACK_n, BERR_n, VPA_n, BR_n and BGACK_n are synchronised with 2 flops.
- E generator:
  - e_cnt advances on c_fall and wraps from E_DIV-1 to 0.
  - E goes 0 when e_cnt reaches E_DIV-1 and 1 when it reaches E_RISE.
- Queue:
  - cmd_ready = !full. A push occurs when cmd_valid && cmd_ready.
  - A pop occurs only on the IDLE->S1 transition.
  - Simultaneous push and pop is legal when not full; the count is unchanged.
  - A push while full is impossible because ready is low. There is no bypass: a command written into an empty queue is popped no earlier than the next cycle.
- Byte lanes:
  - Word access: UDS and LDS both asserted.
  - Byte access: UDS_n = addr[0], LDS_n = !addr[0].
- Arbitration:
  - In IDLE with BR_n low on 2 consecutive synced samples: BG_n goes 0, state goes to GRANT.
  - GRANT: when BGACK_n is low, BUS_OE = 0.
  - GRANT returns to IDLE (BG_n = 1, BUS_OE = 1) when BR_n and BGACK_n are both high.
  - When arbitration and a queued command coincide in IDLE, BR wins.
- States:
  - IDLE: if the queue is non-empty, BGACK_n is high and BR is not qualified, pop the command and go to S1.
  - S1: on c_rise, drive A, FC and RW, set AS_n = 0. For a read, assert the strobes now. Go to S2.
  - S2: for a write, set D_OE = 1 and drive D_OUT immediately; assert the strobes on c_fall. Go to S3 on c_fall.
  - S3: on each c_rise:
    - If DTACK_n = 0, BERR_n = 0, or (VMA_n = 0 and e_cnt == E_DIV-2), go to S4.
    - Else if VPA_n = 0 and e_cnt == 2, set VMA_n = 0.
    - tmo_cnt increments. When it reaches TIMEOUT_CYC, set tmo and go to S4.
  - S4: go to S5 on c_fall.
  - S5: go to S6 on c_rise.
  - S6: on c_fall, latch M68K_D_IN into rsp_rdata, set VMA_n = 1, go to S7.
  - S7: for one PI_CLK, release AS, UDS and LDS, set D_OE = 0 and RW = 1.
    - For a read: pulse rsp_valid with rsp_berr/rsp_tmo.
    - For a write that had BERR or tmo: set err_sticky.
    - Go to IDLE.
- Errors:
  - BERR takes priority over timeout when both occur on the same c_rise.
  - err_clr and a new error on the same cycle: err_sticky = 1.
- busy = (queue non-empty) || (state not in {IDLE, GRANT}).

Test Plan:
- Reset, then push a word read to 0x00BFE001 with FC = 5; DTACK low 2 clocks after AS -> UDS and LDS both low; rsp_valid pulses once with rsp_rdata equal to the value on D_IN at the S6 fall; busy returns to 0.
- Push 4 byte writes to addrs 0x10, 0x11, 0x12, 0x13 back-to-back with FIFO_DEPTH = 4 -> cmd_ready drops after the 4th push; four cycles run in order with UDS/LDS alternating low, high, low, high; no rsp_valid.
- Read with VPA low and no DTACK -> VMA_n goes low at e_cnt == 2; the cycle ends at e_cnt == 8; E low at count 9, high at count 5.
- Write with no DTACK and TIMEOUT_CYC = 16 -> S3 exits after 16 c_rise; err_sticky = 1; err_clr clears it; the next queued command still runs.
- Queue non-empty while BR low -> BG_n = 0 before any AS. With BGACK low: BUS_OE = 0 and no strobes. After BR and BGACK are released, the queued cycle runs.
- Assert PI_RST during S3 of a read -> AS/UDS/LDS = 1 and D_OE = 0 next cycle; queue empty; no rsp_valid.

Source files
------------

// File: rtl/m68k_bus_master_q.sv
// Queued 68000 bus-cycle engine: command FIFO, CPU-clock-timed S0..S7 sequencing,
// E/VPA/VMA peripheral cycles, DTACK timeout, sticky write errors and BR/BG/BGACK arbitration.
module m68k_bus_master_q #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_W      = 24,
    parameter int SYNC_STAGES = 3,
    parameter int E_DIV       = 10,
    parameter int E_RISE      = 5,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              PI_CLK,
    input  logic              PI_RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [15:0]       cmd_wdata,
    input  logic              cmd_rw,
    input  logic              cmd_byte,
    input  logic [2:0]        cmd_fc,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_berr,
    output logic              rsp_tmo,
    output logic              err_sticky,
    input  logic              err_clr,
    output logic              busy,
    input  logic              M68K_CLK,
    output logic [ADDR_W-1:0] M68K_A,
    output logic [15:0]       M68K_D_OUT,
    input  logic [15:0]       M68K_D_IN,
    output logic              M68K_D_OE,
    output logic              M68K_AS_n,
    output logic              M68K_UDS_n,
    output logic              M68K_LDS_n,
    output logic              M68K_RW,
    output logic              M68K_VMA_n,
    output logic [2:0]        M68K_FC,
    output logic              M68K_BUS_OE,
    input  logic              M68K_DTACK_n,
    input  logic              M68K_BERR_n,
    input  logic              M68K_VPA_n,
    input  logic              M68K_BR_n,
    input  logic              M68K_BGACK_n,
    output logic              M68K_BG_n,
    output logic              M68K_E
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = (E_DIV > 1) ? $clog2(E_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = ADDR_W + 21;

    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [EW-1:0] E_LAST    = EW'(E_DIV - 1);
    localparam logic [EW-1:0] E_HIGH    = EW'(E_RISE);
    localparam logic [EW-1:0] E_END     = EW'(E_DIV - 2);
    localparam logic [EW-1:0] E_VMA     = EW'(2);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC);

    typedef enum logic [3:0] {
        IDLE, GRANT, S1, S2, S3, S4, S5, S6, S7
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [4:0]             in_meta_reg;
    logic [4:0]             in_sync_reg;
    logic                   br_prev_reg;
    logic                   c_rise, c_fall;
    logic                   dtack_s, berr_s, vpa_s, br_s, bgack_s, br_qual;

    always_ff @(posedge PI_CLK) begin
        if (PI_RST) begin
            clk_sync_reg <= '0;
            in_meta_reg  <= '1;
            in_sync_reg  <= '1;
            br_prev_reg  <= 1'b1;
        end else begin
            clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], M68K_CLK};
            in_meta_reg  <= {M68K_BGACK_n, M68K_BR_n, M68K_VPA_n, M68K_BERR_n, M68K_DTACK_n};
            in_sync_reg  <= in_meta_reg;
            br_prev_reg  <= in_sync_reg[3];
        end
    end

    // Index 0 is the newest stage, so an edge shows as a disagreement of the last two.
    assign c_rise  = clk_sync_reg[SYNC_STAGES-2] & ~clk_sync_reg[SYNC_STAGES-1];
    assign c_fall  = ~clk_sync_reg[SYNC_STAGES-2] & clk_sync_reg[SYNC_STAGES-1];
    assign dtack_s = in_sync_reg[0];
    assign berr_s  = in_sync_reg[1];
    assign vpa_s   = in_sync_reg[2];
    assign br_s    = in_sync_reg[3];
    assign bgack_s = in_sync_reg[4];
    assign br_qual = ~br_s & ~br_prev_reg;

    // ------------------------------------------------------------------
    // E clock generator
    // ------------------------------------------------------------------
    logic [EW-1:0] e_cnt_reg;
    logic [EW-1:0] e_cnt_adv;
    logic          e_reg;

    assign e_cnt_adv = (e_cnt_reg == E_LAST) ? '0 : e_cnt_reg + 1'b1;

    always_ff @(posedge PI_CLK) begin
        if (PI_RST) begin
            e_cnt_reg <= '0;
            e_reg     <= 1'b1;
        end else if (c_fall) begin
            e_cnt_reg <= e_cnt_adv;
            if (e_cnt_adv == E_LAST)
                e_reg <= 1'b0;
            else if (e_cnt_adv == E_HIGH)
                e_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    logic [CW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [CW-1:0] cur_cmd_reg;
    logic          push, pop, empty;

    assign cmd_ready = (count_reg != DEPTH_C);
    assign empty     = (count_reg == '0);
    assign push      = cmd_valid & cmd_ready;

    always_ff @(posedge PI_CLK) begin
        if (push)
            mem[wr_ptr_reg] <= {cmd_addr, cmd_wdata, cmd_rw, cmd_byte, cmd_fc};
        if (pop)
            cur_cmd_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge PI_CLK) begin
        if (PI_RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    logic [ADDR_W-1:0] cur_addr;
    logic [15:0]       cur_wdata;
    logic              cur_rw, cur_byte;
    logic [2:0]        cur_fc;
    logic              uds_lane, lds_lane;

    assign cur_addr  = cur_cmd_reg[CW-1 -: ADDR_W];
    assign cur_wdata = cur_cmd_reg[20:5];
    assign cur_rw    = cur_cmd_reg[4];
    assign cur_byte  = cur_cmd_reg[3];
    assign cur_fc    = cur_cmd_reg[2:0];
    assign uds_lane  = cur_byte & cur_addr[0];
    assign lds_lane  = cur_byte & ~cur_addr[0];

    // ------------------------------------------------------------------
    // Bus-cycle FSM
    // ------------------------------------------------------------------
    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] a_reg, a_next;
    logic [15:0]       d_out_reg, d_out_next;
    logic [2:0]        fc_reg, fc_next;
    logic              as_n_reg, as_n_next, uds_n_reg, uds_n_next, lds_n_reg, lds_n_next;
    logic              rw_reg, rw_next, vma_n_reg, vma_n_next, bg_n_reg, bg_n_next;
    logic              bus_oe_reg, bus_oe_next, d_oe_reg, d_oe_next;
    logic [TW-1:0]     tmo_cnt_reg, tmo_cnt_next;
    logic              berr_flag_reg, berr_flag_next, tmo_flag_reg, tmo_flag_next;
    logic [15:0]       rdata_reg, rdata_next;
    logic              rsp_valid_reg, rsp_valid_next, rsp_berr_reg, rsp_berr_next;
    logic              rsp_tmo_reg, rsp_tmo_next, err_sticky_reg, err_set;

    always_ff @(posedge PI_CLK) begin
        if (PI_RST) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            d_out_reg      <= '0;
            fc_reg         <= 3'b111;
            as_n_reg       <= 1'b1;
            uds_n_reg      <= 1'b1;
            lds_n_reg      <= 1'b1;
            rw_reg         <= 1'b1;
            vma_n_reg      <= 1'b1;
            bg_n_reg       <= 1'b1;
            bus_oe_reg     <= 1'b1;
            d_oe_reg       <= 1'b0;
            tmo_cnt_reg    <= '0;
            berr_flag_reg  <= 1'b0;
            tmo_flag_reg   <= 1'b0;
            rdata_reg      <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_berr_reg   <= 1'b0;
            rsp_tmo_reg    <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            a_reg          <= a_next;
            d_out_reg      <= d_out_next;
            fc_reg         <= fc_next;
            as_n_reg       <= as_n_next;
            uds_n_reg      <= uds_n_next;
            lds_n_reg      <= lds_n_next;
            rw_reg         <= rw_next;
            vma_n_reg      <= vma_n_next;
            bg_n_reg       <= bg_n_next;
            bus_oe_reg     <= bus_oe_next;
            d_oe_reg       <= d_oe_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            berr_flag_reg  <= berr_flag_next;
            tmo_flag_reg   <= tmo_flag_next;
            rdata_reg      <= rdata_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_berr_reg   <= rsp_berr_next;
            rsp_tmo_reg    <= rsp_tmo_next;
            // A new error outranks a clear arriving in the same cycle.
            if (err_set)
                err_sticky_reg <= 1'b1;
            else if (err_clr)
                err_sticky_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pop            = 1'b0;
        a_next         = a_reg;
        d_out_next     = d_out_reg;
        fc_next        = fc_reg;
        as_n_next      = as_n_reg;
        uds_n_next     = uds_n_reg;
        lds_n_next     = lds_n_reg;
        rw_next        = rw_reg;
        vma_n_next     = vma_n_reg;
        bg_n_next      = bg_n_reg;
        bus_oe_next    = bus_oe_reg;
        d_oe_next      = d_oe_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        berr_flag_next = berr_flag_reg;
        tmo_flag_next  = tmo_flag_reg;
        rdata_next     = rdata_reg;
        rsp_valid_next = 1'b0;
        rsp_berr_next  = 1'b0;
        rsp_tmo_next   = 1'b0;
        err_set        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (br_qual) begin
                    bg_n_next  = 1'b0;
                    state_next = GRANT;
                end else if (!empty && bgack_s) begin
                    pop        = 1'b1;
                    state_next = S1;
                end
            end
            GRANT: begin
                if (!bgack_s)
                    bus_oe_next = 1'b0;
                if (br_s && bgack_s) begin
                    bg_n_next   = 1'b1;
                    bus_oe_next = 1'b1;
                    state_next  = IDLE;
                end
            end
            S1: begin
                tmo_cnt_next   = '0;
                berr_flag_next = 1'b0;
                tmo_flag_next  = 1'b0;
                if (c_rise) begin
                    a_next    = cur_addr;
                    fc_next   = cur_fc;
                    rw_next   = cur_rw;
                    as_n_next = 1'b0;
                    if (cur_rw) begin
                        uds_n_next = uds_lane;
                        lds_n_next = lds_lane;
                    end
                    state_next = S2;
                end
            end
            S2: begin
                if (!cur_rw) begin
                    d_oe_next  = 1'b1;
                    d_out_next = cur_wdata;
                end
                if (c_fall) begin
                    uds_n_next = uds_lane;
                    lds_n_next = lds_lane;
                    state_next = S3;
                end
            end
            S3: begin
                if (c_rise) begin
                    if (!dtack_s || !berr_s || (!vma_n_reg && e_cnt_reg == E_END)) begin
                        berr_flag_next = ~berr_s;
                        state_next     = S4;
                    end else begin
                        if (!vpa_s && e_cnt_reg == E_VMA)
                            vma_n_next = 1'b0;
                        tmo_cnt_next = tmo_cnt_reg + 1'b1;
                        if (tmo_cnt_next == TMO_LIMIT) begin
                            tmo_flag_next = 1'b1;
                            state_next    = S4;
                        end
                    end
                end
            end
            S4: begin
                if (c_fall)
                    state_next = S5;
            end
            S5: begin
                if (c_rise)
                    state_next = S6;
            end
            S6: begin
                if (c_fall) begin
                    rdata_next = M68K_D_IN;
                    vma_n_next = 1'b1;
                    state_next = S7;
                end
            end
            S7: begin
                as_n_next  = 1'b1;
                uds_n_next = 1'b1;
                lds_n_next = 1'b1;
                d_oe_next  = 1'b0;
                rw_next    = 1'b1;
                if (cur_rw) begin
                    rsp_valid_next = 1'b1;
                    rsp_berr_next  = berr_flag_reg;
                    rsp_tmo_next   = tmo_flag_reg & ~berr_flag_reg;
                end else begin
                    err_set = berr_flag_reg | tmo_flag_reg;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy        = !empty || !(state_reg == IDLE || state_reg == GRANT);
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rdata_reg;
    assign rsp_berr    = rsp_berr_reg;
    assign rsp_tmo     = rsp_tmo_reg;
    assign err_sticky  = err_sticky_reg;
    assign M68K_A      = a_reg;
    assign M68K_D_OUT  = d_out_reg;
    assign M68K_D_OE   = d_oe_reg;
    assign M68K_AS_n   = as_n_reg;
    assign M68K_UDS_n  = uds_n_reg;
    assign M68K_LDS_n  = lds_n_reg;
    assign M68K_RW     = rw_reg;
    assign M68K_VMA_n  = vma_n_reg;
    assign M68K_FC     = fc_reg;
    assign M68K_BUS_OE = bus_oe_reg;
    assign M68K_BG_n   = bg_n_reg;
    assign M68K_E      = e_reg;

endmodule

// File: tb/tb_m68k_bus_master_q.sv
// Directed bench for m68k_bus_master_q: queued reads/writes, VPA cycle, timeout,
// BERR, arbitration and mid-cycle reset, with hand-computed expectations.
module tb_m68k_bus_master_q;

    logic        PI_CLK = 1'b0;
    logic        PI_RST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [23:0] cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic        cmd_rw = 1'b0;
    logic        cmd_byte = 1'b0;
    logic [2:0]  cmd_fc = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_berr, rsp_tmo, err_sticky;
    logic        err_clr = 1'b0;
    logic        busy;
    logic        M68K_CLK = 1'b0;
    logic [23:0] M68K_A;
    logic [15:0] M68K_D_OUT;
    logic [15:0] M68K_D_IN = '0;
    logic        M68K_D_OE, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_VMA_n;
    logic [2:0]  M68K_FC;
    logic        M68K_BUS_OE;
    logic        M68K_DTACK_n = 1'b1, M68K_BERR_n = 1'b1, M68K_VPA_n = 1'b1;
    logic        M68K_BR_n = 1'b1, M68K_BGACK_n = 1'b1;
    logic        M68K_BG_n, M68K_E;

    m68k_bus_master_q #(
        .FIFO_DEPTH(4), .ADDR_W(24), .SYNC_STAGES(3),
        .E_DIV(10), .E_RISE(5), .TIMEOUT_CYC(16)
    ) dut (
        .PI_CLK(PI_CLK), .PI_RST(PI_RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_rw(cmd_rw), .cmd_byte(cmd_byte), .cmd_fc(cmd_fc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_berr(rsp_berr), .rsp_tmo(rsp_tmo),
        .err_sticky(err_sticky), .err_clr(err_clr), .busy(busy),
        .M68K_CLK(M68K_CLK), .M68K_A(M68K_A), .M68K_D_OUT(M68K_D_OUT), .M68K_D_IN(M68K_D_IN),
        .M68K_D_OE(M68K_D_OE), .M68K_AS_n(M68K_AS_n), .M68K_UDS_n(M68K_UDS_n),
        .M68K_LDS_n(M68K_LDS_n), .M68K_RW(M68K_RW), .M68K_VMA_n(M68K_VMA_n),
        .M68K_FC(M68K_FC), .M68K_BUS_OE(M68K_BUS_OE),
        .M68K_DTACK_n(M68K_DTACK_n), .M68K_BERR_n(M68K_BERR_n), .M68K_VPA_n(M68K_VPA_n),
        .M68K_BR_n(M68K_BR_n), .M68K_BGACK_n(M68K_BGACK_n),
        .M68K_BG_n(M68K_BG_n), .M68K_E(M68K_E)
    );

    // 100 MHz Pi clock, 12.5 MHz CPU clock: one CPU period is 8 Pi cycles.
    always #5 PI_CLK = ~PI_CLK;
    always #40 M68K_CLK = ~M68K_CLK;

    int checks = 0;
    int errors = 0;

    // Results of the most recent bus cycle observed by run_cycle.
    logic [23:0] r_a;
    logic [2:0]  r_fc;
    logic        r_rw, r_uds, r_lds, r_doe, r_berr, r_tmo, r_vma_fall_e;
    logic [15:0] r_dout, r_rdata;
    int          r_nrsp, r_as_len, r_vma_len, r_vma_since;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [23:0] a, input logic [15:0] wd, input logic rw,
                        input logic byt, input logic [2:0] fc);
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_rw    = rw;
        cmd_byte  = byt;
        cmd_fc    = fc;
        cmd_valid = 1'b1;
        @(negedge PI_CLK);
        cmd_valid = 1'b0;
    endtask

    task automatic idle_watch(input int n, output int as_lows, output int rsps);
        as_lows = 0;
        rsps    = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge PI_CLK);
            if (M68K_AS_n === 1'b0) as_lows++;
            if (rsp_valid === 1'b1) rsps++;
        end
    endtask

    // mode 0: no termination, 1: DTACK, 2: BERR -- asserted 2 CPU clocks after AS.
    task automatic run_cycle(input int mode, input string tag);
        int   n;
        int   e_since;
        logic e_prev, vma_prev;
        r_nrsp = 0; r_as_len = 0; r_vma_len = 0; r_vma_since = -1; r_vma_fall_e = 1'bx;
        r_berr = 1'bx; r_tmo = 1'bx; r_rdata = 'x;
        e_since = 1000; e_prev = M68K_E; vma_prev = M68K_VMA_n;
        n = 0;
        while (M68K_AS_n !== 1'b0 && n < 2000) begin
            @(negedge PI_CLK);
            n++;
            if (e_prev && !M68K_E) e_since = 0; else e_since++;
            e_prev = M68K_E;
            if (rsp_valid === 1'b1) r_nrsp++;
        end
        check({tag, "_as_start"}, {31'b0, M68K_AS_n}, 32'd0);
        r_a = M68K_A; r_fc = M68K_FC; r_rw = M68K_RW;
        n = 0;
        while (M68K_AS_n === 1'b0 && n < 3000) begin
            r_as_len++;
            n++;
            if (r_as_len == 16) begin
                r_uds = M68K_UDS_n; r_lds = M68K_LDS_n; r_doe = M68K_D_OE; r_dout = M68K_D_OUT;
                if (mode == 1) M68K_DTACK_n = 1'b0;
                if (mode == 2) M68K_BERR_n = 1'b0;
            end
            @(negedge PI_CLK);
            if (e_prev && !M68K_E) e_since = 0; else e_since++;
            e_prev = M68K_E;
            if (vma_prev && !M68K_VMA_n) begin
                r_vma_since  = e_since;
                r_vma_fall_e = M68K_E;
            end
            vma_prev = M68K_VMA_n;
            if (M68K_VMA_n === 1'b0) r_vma_len++;
            if (rsp_valid === 1'b1) begin
                r_nrsp++; r_rdata = rsp_rdata; r_berr = rsp_berr; r_tmo = rsp_tmo;
            end
        end
        check({tag, "_as_end"}, {31'b0, M68K_AS_n}, 32'd1);
        M68K_DTACK_n = 1'b1;
        M68K_BERR_n  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge PI_CLK);
            if (rsp_valid === 1'b1) begin
                r_nrsp++; r_rdata = rsp_rdata; r_berr = rsp_berr; r_tmo = rsp_tmo;
            end
        end
        $display("txn %s a=%06h fc=%0d rw=%0b uds=%0b lds=%0b dout=%04h as_len=%0d rsp=%0d rdata=%04h berr=%0b tmo=%0b",
                 tag, r_a, r_fc, r_rw, r_uds, r_lds, r_dout, r_as_len, r_nrsp, r_rdata, r_berr, r_tmo);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int as_lows, rsps, n, elo, ehi;
        logic [23:0] wa;

        // Reset values, sampled while reset is still held.
        repeat (5) @(negedge PI_CLK);
        check("rst_as",     {31'b0, M68K_AS_n},   32'd1);
        check("rst_uds",    {31'b0, M68K_UDS_n},  32'd1);
        check("rst_lds",    {31'b0, M68K_LDS_n},  32'd1);
        check("rst_rw",     {31'b0, M68K_RW},     32'd1);
        check("rst_vma",    {31'b0, M68K_VMA_n},  32'd1);
        check("rst_bg",     {31'b0, M68K_BG_n},   32'd1);
        check("rst_e",      {31'b0, M68K_E},      32'd1);
        check("rst_fc",     {29'b0, M68K_FC},     32'd7);
        check("rst_doe",    {31'b0, M68K_D_OE},   32'd0);
        check("rst_busoe",  {31'b0, M68K_BUS_OE}, 32'd1);
        check("rst_ready",  {31'b0, cmd_ready},   32'd1);
        check("rst_rspv",   {31'b0, rsp_valid},   32'd0);
        check("rst_sticky", {31'b0, err_sticky},  32'd0);
        check("rst_busy",   {31'b0, busy},        32'd0);
        PI_RST = 1'b0;

        // E clock: low for counts 9,0..4 (6 CPU clocks), high for 5..8 (4 CPU clocks).
        n = 0;
        while (M68K_E !== 1'b0 && n < 300) begin @(negedge PI_CLK); n++; end
        elo = 0;
        while (M68K_E === 1'b0 && elo < 300) begin elo++; @(negedge PI_CLK); end
        ehi = 0;
        while (M68K_E === 1'b1 && ehi < 300) begin ehi++; @(negedge PI_CLK); end
        check("e_low_len",  elo, 32'd48);
        check("e_high_len", ehi, 32'd32);

        // Word read with DTACK.
        M68K_D_IN = 16'hA55A;
        push(24'hBFE001, 16'h0000, 1'b1, 1'b0, 3'd5);
        run_cycle(1, "rd_word");
        check("rd_word_a",     r_a,    32'h00BFE001);
        check("rd_word_fc",    r_fc,   32'd5);
        check("rd_word_rw",    r_rw,   32'd1);
        check("rd_word_uds",   r_uds,  32'd0);
        check("rd_word_lds",   r_lds,  32'd0);
        check("rd_word_nrsp",  r_nrsp, 32'd1);
        check("rd_word_rdata", r_rdata, 32'h0000A55A);
        check("rd_word_berr",  r_berr, 32'd0);
        check("rd_word_tmo",   r_tmo,  32'd0);
        check("rd_word_busy",  {31'b0, busy}, 32'd0);

        // Four byte writes queued while an external master holds BGACK.
        M68K_BGACK_n = 1'b0;
        repeat (4) @(negedge PI_CLK);
        push(24'h000010, 16'h1100, 1'b0, 1'b1, 3'd1);
        push(24'h000011, 16'h1101, 1'b0, 1'b1, 3'd1);
        push(24'h000012, 16'h1102, 1'b0, 1'b1, 3'd1);
        check("q_ready_3", {31'b0, cmd_ready}, 32'd1);
        push(24'h000013, 16'h1103, 1'b0, 1'b1, 3'd1);
        check("q_ready_4", {31'b0, cmd_ready}, 32'd0);
        check("q_busy",    {31'b0, busy},      32'd1);
        M68K_BGACK_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wa = 24'h000010 + 24'(i);
            run_cycle(1, "wr_byte");
            check("wr_byte_a",    r_a,    {8'h00, wa});
            check("wr_byte_rw",   r_rw,   32'd0);
            check("wr_byte_uds",  r_uds,  {31'b0, wa[0]});
            check("wr_byte_lds",  r_lds,  {31'b0, ~wa[0]});
            check("wr_byte_doe",  r_doe,  32'd1);
            check("wr_byte_dout", r_dout, 32'h1100 + 32'(i));
            check("wr_byte_nrsp", r_nrsp, 32'd0);
        end
        check("wr_sticky", {31'b0, err_sticky}, 32'd0);

        // Synchronous-peripheral read: VPA low, no DTACK.
        M68K_VPA_n = 1'b0;
        M68K_D_IN  = 16'h3C3C;
        push(24'hF00000, 16'h0000, 1'b1, 1'b0, 3'd5);
        run_cycle(0, "rd_vpa");
        M68K_VPA_n = 1'b1;
        check("vpa_e_at_vma",  r_vma_fall_e, 32'd0);
        check("vpa_vma_since", r_vma_since,  32'd28);
        check("vpa_vma_len",   r_vma_len,    32'd60);
        check("vpa_nrsp",      r_nrsp,       32'd1);
        check("vpa_rdata",     r_rdata,      32'h00003C3C);
        check("vpa_tmo",       r_tmo,        32'd0);
        check("vpa_berr",      r_berr,       32'd0);

        // Write timeout sets err_sticky; the read queued behind it still runs.
        push(24'h000020, 16'hBEEF, 1'b0, 1'b0, 3'd1);
        push(24'h000022, 16'h0000, 1'b1, 1'b0, 3'd1);
        M68K_D_IN = 16'h1234;
        run_cycle(0, "wr_tmo");
        check("wr_tmo_as_len", r_as_len, 32'd141);
        check("wr_tmo_nrsp",   r_nrsp,   32'd0);
        check("wr_tmo_sticky", {31'b0, err_sticky}, 32'd1);
        err_clr = 1'b1;
        @(negedge PI_CLK);
        err_clr = 1'b0;
        check("sticky_clr", {31'b0, err_sticky}, 32'd0);
        run_cycle(1, "rd_after");
        check("rd_after_a",     r_a,     32'h00000022);
        check("rd_after_nrsp",  r_nrsp,  32'd1);
        check("rd_after_rdata", r_rdata, 32'h00001234);
        check("rd_after_tmo",   r_tmo,   32'd0);

        // Read ended by BERR, then read ended by timeout.
        push(24'h000100, 16'h0000, 1'b1, 1'b0, 3'd2);
        run_cycle(2, "rd_berr");
        check("rd_berr_nrsp", r_nrsp, 32'd1);
        check("rd_berr_berr", r_berr, 32'd1);
        check("rd_berr_tmo",  r_tmo,  32'd0);
        push(24'h000102, 16'h0000, 1'b1, 1'b0, 3'd2);
        run_cycle(0, "rd_tmo");
        check("rd_tmo_as_len", r_as_len, 32'd141);
        check("rd_tmo_nrsp",   r_nrsp,   32'd1);
        check("rd_tmo_tmo",    r_tmo,    32'd1);
        check("rd_tmo_berr",   r_berr,   32'd0);
        check("rd_sticky",     {31'b0, err_sticky}, 32'd0);

        // Arbitration: grant before any cycle, tristate under BGACK, then resume.
        M68K_BR_n = 1'b0;
        idle_watch(8, as_lows, rsps);
        check("arb_bg", {31'b0, M68K_BG_n}, 32'd0);
        push(24'h000040, 16'h0000, 1'b1, 1'b0, 3'd6);
        M68K_BGACK_n = 1'b0;
        idle_watch(8, n, rsps);
        as_lows += n;
        check("arb_busoe",  {31'b0, M68K_BUS_OE}, 32'd0);
        check("arb_busy",   {31'b0, busy},        32'd1);
        check("arb_no_as",  as_lows,              32'd0);
        M68K_BR_n    = 1'b1;
        M68K_BGACK_n = 1'b1;
        run_cycle(1, "rd_arb");
        check("arb_bg_rel",    {31'b0, M68K_BG_n},   32'd1);
        check("arb_busoe_rel", {31'b0, M68K_BUS_OE}, 32'd1);
        check("arb_rd_a",      r_a,    32'h00000040);
        check("arb_rd_nrsp",   r_nrsp, 32'd1);

        // Reset during S3 of a read with a write still queued.
        push(24'h000030, 16'h0000, 1'b1, 1'b0, 3'd5);
        push(24'h000032, 16'h5555, 1'b0, 1'b0, 3'd1);
        n = 0;
        while (M68K_AS_n !== 1'b0 && n < 2000) begin @(negedge PI_CLK); n++; end
        check("mrst_as_start", {31'b0, M68K_AS_n}, 32'd0);
        repeat (20) @(negedge PI_CLK);
        PI_RST = 1'b1;
        @(negedge PI_CLK);
        PI_RST = 1'b0;
        check("mrst_as",    {31'b0, M68K_AS_n},  32'd1);
        check("mrst_uds",   {31'b0, M68K_UDS_n}, 32'd1);
        check("mrst_lds",   {31'b0, M68K_LDS_n}, 32'd1);
        check("mrst_doe",   {31'b0, M68K_D_OE},  32'd0);
        check("mrst_ready", {31'b0, cmd_ready},  32'd1);
        check("mrst_busy",  {31'b0, busy},       32'd0);
        idle_watch(300, as_lows, rsps);
        check("mrst_no_as",  as_lows, 32'd0);
        check("mrst_no_rsp", rsps,    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
